tlb_lookup_arbiter: RTL

TLB_LOOKUP_ARBITER -- requirements
Module: tlb_lookup_arbiter

---
 rtl/tlb_lookup_arbiter_pkg.sv | 28 ++
 rtl/tlb_lookup_arbiter_page_select.sv | 40 ++++
 rtl/tlb_lookup_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/tlb_lookup_arbiter_pkg.sv
// Shared widths, FSM state encoding and TLB page-mask constants for the
// instruction/data TLB lookup arbiter.
package tlb_lookup_arbiter_pkg;

  localparam int VPN_W  = 20;
  localparam int VPN2_W = 19;
  localparam int PFN_W  = 20;
  localparam int MASK_W = 16;
  // Largest page size selects on VPN[16], so only the low 17 VPN bits matter here
  localparam int SEL_W  = 17;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  localparam logic [MASK_W-1:0] MASK_4K   = 16'h0000;
  localparam logic [MASK_W-1:0] MASK_16K  = 16'h0003;
  localparam logic [MASK_W-1:0] MASK_64K  = 16'h000F;
  localparam logic [MASK_W-1:0] MASK_256K = 16'h003F;
  localparam logic [MASK_W-1:0] MASK_1M   = 16'h00FF;
  localparam logic [MASK_W-1:0] MASK_4M   = 16'h03FF;
  localparam logic [MASK_W-1:0] MASK_16M  = 16'h0FFF;
  localparam logic [MASK_W-1:0] MASK_64M  = 16'h3FFF;
  localparam logic [MASK_W-1:0] MASK_256M = 16'hFFFF;

endpackage

// File: rtl/tlb_lookup_arbiter_page_select.sv
// Combinational even/odd page selection for a matched TLB entry pair:
// picks the odd-select VPN bit from the page mask, then muxes PFN/V/D.
module tlb_page_select
  import tlb_lookup_arbiter_pkg::*;
(
  input  logic [SEL_W-1:0]  vpn_sel,
  input  logic [MASK_W-1:0] mask,
  input  logic [PFN_W-1:0]  pfn0,
  input  logic [PFN_W-1:0]  pfn1,
  input  logic              v0,
  input  logic              v1,
  input  logic              d0,
  input  logic              d1,
  output logic [PFN_W-1:0]  pfn,
  output logic              valid,
  output logic              dirty
);

  logic odd;

  // Unsupported mask encodings fall back to the even page
  always_comb begin
    case (mask)
      MASK_4K:   odd = vpn_sel[0];
      MASK_16K:  odd = vpn_sel[2];
      MASK_64K:  odd = vpn_sel[4];
      MASK_256K: odd = vpn_sel[6];
      MASK_1M:   odd = vpn_sel[8];
      MASK_4M:   odd = vpn_sel[10];
      MASK_16M:  odd = vpn_sel[12];
      MASK_64M:  odd = vpn_sel[14];
      MASK_256M: odd = vpn_sel[16];
      default:   odd = 1'b0;
    endcase
    pfn   = odd ? pfn1 : pfn0;
    valid = odd ? v1 : v0;
    dirty = odd ? d1 : d0;
  end

endmodule

// File: rtl/tlb_lookup_arbiter.sv
// Arbitrates instruction and data lookups onto one shared TLB search port.
// Define TLB_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise data always wins.
module tlb_lookup_arbiter
  import tlb_lookup_arbiter_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              I_Req,
  input  logic [VPN_W-1:0]  I_VPN,
  output logic              I_Ack,
  output logic [PFN_W-1:0]  I_PFN,
  output logic              I_Miss,
  output logic              I_Invalid,
  input  logic              D_Req,
  input  logic              D_Write,
  input  logic [VPN_W-1:0]  D_VPN,
  output logic              D_Ack,
  output logic [PFN_W-1:0]  D_PFN,
  output logic              D_Miss,
  output logic              D_Invalid,
  output logic              D_Modified,
  output logic              Tlb_Req,
  output logic [VPN2_W-1:0] Tlb_VPN2,
  input  logic              Tlb_Busy,
  input  logic              Tlb_Hit,
  input  logic [MASK_W-1:0] Tlb_Mask,
  input  logic [PFN_W-1:0]  Tlb_PFN0,
  input  logic [PFN_W-1:0]  Tlb_PFN1,
  input  logic              Tlb_V0,
  input  logic              Tlb_V1,
  input  logic              Tlb_D0,
  input  logic              Tlb_D1
);

  arb_state_e       state_q, state_d;
  logic [VPN_W-1:0] vpn_q, vpn_d;
  logic             write_q, write_d;
  logic             grant_data_q, grant_data_d;
  logic             i_ack_q, i_ack_d;
  logic             d_ack_q, d_ack_d;
  logic [PFN_W-1:0] i_pfn_q, i_pfn_d;
  logic [PFN_W-1:0] d_pfn_q, d_pfn_d;
  logic             i_miss_q, i_miss_d;
  logic             i_invalid_q, i_invalid_d;
  logic             d_miss_q, d_miss_d;
  logic             d_invalid_q, d_invalid_d;
  logic             d_modified_q, d_modified_d;
`ifdef TLB_ARB_ROUND_ROBIN_EN
  logic             last_data_q, last_data_d;
`endif

  logic             pick_data;
  logic             start;
  logic [VPN_W-1:0] win_vpn;
  logic [PFN_W-1:0] sel_pfn;
  logic             sel_valid;
  logic             sel_dirty;
  logic             res_miss;
  logic             res_invalid;
  logic             res_modified;

  tlb_page_select u_page_select (
    .vpn_sel (vpn_q[SEL_W-1:0]),
    .mask    (Tlb_Mask),
    .pfn0    (Tlb_PFN0),
    .pfn1    (Tlb_PFN1),
    .v0      (Tlb_V0),
    .v1      (Tlb_V1),
    .d0      (Tlb_D0),
    .d1      (Tlb_D1),
    .pfn     (sel_pfn),
    .valid   (sel_valid),
    .dirty   (sel_dirty)
  );

  // The search strobe goes out in the granting IDLE cycle so the TLB answers during LOOKUP
  always_comb begin
`ifdef TLB_ARB_ROUND_ROBIN_EN
    pick_data = D_Req & (~I_Req | ~last_data_q);
`else
    pick_data = D_Req;
`endif
    win_vpn = pick_data ? D_VPN : I_VPN;
    start   = (state_q == ST_IDLE) & (I_Req | D_Req) & ~Tlb_Busy & ~reset;
  end

  always_comb begin
    res_miss     = ~Tlb_Hit;
    res_invalid  = Tlb_Hit & ~sel_valid;
    res_modified = Tlb_Hit & sel_valid & write_q & ~sel_dirty;
  end

  always_comb begin
    state_d      = state_q;
    vpn_d        = vpn_q;
    write_d      = write_q;
    grant_data_d = grant_data_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    i_pfn_d      = i_pfn_q;
    d_pfn_d      = d_pfn_q;
    i_miss_d     = i_miss_q;
    i_invalid_d  = i_invalid_q;
    d_miss_d     = d_miss_q;
    d_invalid_d  = d_invalid_q;
    d_modified_d = d_modified_q;
`ifdef TLB_ARB_ROUND_ROBIN_EN
    last_data_d  = last_data_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          vpn_d        = win_vpn;
          write_d      = pick_data & D_Write;
          grant_data_d = pick_data;
`ifdef TLB_ARB_ROUND_ROBIN_EN
          last_data_d  = pick_data;
`endif
          state_d      = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        // Only the winner's result registers change, so the other side holds its last answer
        if (grant_data_q) begin
          d_pfn_d      = sel_pfn;
          d_miss_d     = res_miss;
          d_invalid_d  = res_invalid;
          d_modified_d = res_modified;
          d_ack_d      = 1'b1;
        end else begin
          i_pfn_d      = sel_pfn;
          i_miss_d     = res_miss;
          i_invalid_d  = res_invalid;
          i_ack_d      = 1'b1;
        end
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      vpn_q        <= '0;
      write_q      <= 1'b0;
      grant_data_q <= 1'b0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      i_pfn_q      <= '0;
      d_pfn_q      <= '0;
      i_miss_q     <= 1'b0;
      i_invalid_q  <= 1'b0;
      d_miss_q     <= 1'b0;
      d_invalid_q  <= 1'b0;
      d_modified_q <= 1'b0;
`ifdef TLB_ARB_ROUND_ROBIN_EN
      last_data_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      vpn_q        <= vpn_d;
      write_q      <= write_d;
      grant_data_q <= grant_data_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      i_pfn_q      <= i_pfn_d;
      d_pfn_q      <= d_pfn_d;
      i_miss_q     <= i_miss_d;
      i_invalid_q  <= i_invalid_d;
      d_miss_q     <= d_miss_d;
      d_invalid_q  <= d_invalid_d;
      d_modified_q <= d_modified_d;
`ifdef TLB_ARB_ROUND_ROBIN_EN
      last_data_q  <= last_data_d;
`endif
    end
  end

  assign Tlb_Req    = start;
  assign Tlb_VPN2   = start ? win_vpn[VPN_W-1:1] : vpn_q[VPN_W-1:1];
  assign I_Ack      = i_ack_q;
  assign I_PFN      = i_pfn_q;
  assign I_Miss     = i_miss_q;
  assign I_Invalid  = i_invalid_q;
  assign D_Ack      = d_ack_q;
  assign D_PFN      = d_pfn_q;
  assign D_Miss     = d_miss_q;
  assign D_Invalid  = d_invalid_q;
  assign D_Modified = d_modified_q;

endmodule
